// File: rtl/bus_fifo_in_if.sv
// Device-port bundle between the device-side agent and the bus input FIFO.
// The master side writes packets and pops words; the slave side is the FIFO.
interface bus_fifo_in_if #(
   parameter int pckg_sz   = 32,
   parameter int fifo_size = 8,
   parameter int cnt_w     = 8
);
   localparam int CW = $clog2(fifo_size + 1);

   logic               push_in;
   logic [pckg_sz-1:0] D_in;
   logic               full;
   logic               pop;
   logic               pndng;
   logic [pckg_sz-1:0] D_pop;
   logic [CW-1:0]      count;
   logic [cnt_w-1:0]   ovf_cnt;
   logic [cnt_w-1:0]   drop_cnt;
   logic               udf;

   modport master (
      output push_in, D_in, pop,
      input  full, pndng, D_pop, count, ovf_cnt, drop_cnt, udf
   );

   modport slave (
      input  push_in, D_in, pop,
      output full, pndng, D_pop, count, ovf_cnt, drop_cnt, udf
   );
endinterface

// File: rtl/bus_fifo_in.sv
// Per-device input FIFO feeding the bus arbiter. Drops packets whose
// destination ID is illegal, keeps saturating overflow/drop statistics and
// a sticky underflow flag. Head word is presented first-word fall-through
// from a register, so every output comes straight from flops.
module bus_fifo_in #(
   parameter int         pckg_sz   = 32,
   parameter int         fifo_size = 8,
   parameter int         drvrs     = 4,
   parameter int         id        = 0,
   parameter logic [7:0] broadcast = 8'hFF,
   parameter int         cnt_w     = 8
) (
   input logic          clk,
   input logic          reset,
   bus_fifo_in_if.slave bus
);
   localparam int            CW    = $clog2(fifo_size + 1);
   localparam int            PW    = (fifo_size > 1) ? $clog2(fifo_size) : 1;
   localparam logic [CW-1:0] DEPTH = CW'(fifo_size);
   localparam logic [PW-1:0] LAST  = PW'(fifo_size - 1);
   localparam logic [8:0]    DRV9  = 9'(drvrs);
   localparam logic [7:0]    ID8   = 8'(id);

   logic [pckg_sz-1:0] mem [fifo_size];

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      rd_nxt;
   logic [CW-1:0]      count_q, count_d;
   logic               full_q, full_d;
   logic               pndng_q, pndng_d;
   logic [pckg_sz-1:0] dpop_q, dpop_d;
   logic [cnt_w-1:0]   ovf_q, ovf_d;
   logic [cnt_w-1:0]   drop_q, drop_d;
   logic               udf_q, udf_d;

   logic [7:0]         dest;
   logic               legal;
   logic               pop_eff;
   logic               wr_en;

   // Next-state: destination filter, accept/pop decisions, occupancy and stats
   always_comb begin
      dest     = bus.D_in[pckg_sz-1 -: 8];
      legal    = (({1'b0, dest} < DRV9) && (dest != ID8)) || (dest == broadcast);
      pop_eff  = bus.pop && pndng_q;
      wr_en    = bus.push_in && legal && (!full_q || pop_eff);
      rd_nxt   = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dpop_d   = dpop_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      udf_d    = udf_q;

      if (wr_en) begin
         wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop_eff) begin
         rd_ptr_d = rd_nxt;
      end

      unique case ({wr_en, pop_eff})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == DEPTH);
      pndng_d = (count_d != '0);

      // The incoming word bypasses memory when it becomes the new head:
      // either the FIFO was empty, or the only resident word is being popped.
      if (wr_en && ((count_q == '0) || (pop_eff && (count_q == CW'(1))))) begin
         dpop_d = bus.D_in;
      end else if (pop_eff) begin
         dpop_d = mem[rd_nxt];
      end

      if (bus.push_in && legal && !wr_en && (ovf_q != '1)) begin
         ovf_d = ovf_q + cnt_w'(1);
      end
      if (bus.push_in && !legal && (drop_q != '1)) begin
         drop_d = drop_q + cnt_w'(1);
      end
      if (bus.pop && !pndng_q) begin
         udf_d = 1'b1;
      end
   end

   // Storage array; contents are don't-care after reset so it is not cleared
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem[wr_ptr_q] <= bus.D_in;
      end
   end

   // State and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         pndng_q  <= 1'b0;
         dpop_q   <= '0;
         ovf_q    <= '0;
         drop_q   <= '0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         pndng_q  <= pndng_d;
         dpop_q   <= dpop_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         udf_q    <= udf_d;
      end
   end

   assign bus.full     = full_q;
   assign bus.pndng    = pndng_q;
   assign bus.D_pop    = dpop_q;
   assign bus.count    = count_q;
   assign bus.ovf_cnt  = ovf_q;
   assign bus.drop_cnt = drop_q;
   assign bus.udf      = udf_q;
endmodule

// File: tb/tb_bus_fifo_in.sv
// Bench for bus_fifo_in (drvrs=4, fifo_size=8, id=0, pckg_sz=32).
// A queue-based reference model tracks expected contents and statistics.
module tb_bus_fifo_in;
   logic clk = 1'b0;
   logic reset = 1'b1;

   int total = 0;
   int bad   = 0;

   logic [31:0] mq[$];
   int          m_ovf  = 0;
   int          m_drop = 0;
   bit          m_udf  = 1'b0;

   bus_fifo_in_if #(.pckg_sz(32), .fifo_size(8), .cnt_w(8)) bif ();

   bus_fifo_in #(
      .pckg_sz(32), .fifo_size(8), .drvrs(4), .id(0),
      .broadcast(8'hFF), .cnt_w(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic bit is_legal(input logic [31:0] d);
      logic [7:0] dst;
      dst = d[31:24];
      return ((dst < 8'd4) && (dst != 8'd0)) || (dst == 8'hFF);
   endfunction

   // One clock with the given inputs, then the model takes the same step.
   task automatic drive(input bit p, input logic [31:0] d, input bit po, input bit rst);
      bit pe;
      bif.push_in = p;
      bif.D_in    = d;
      bif.pop     = po;
      reset       = rst ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_drop = 0; m_udf = 1'b0;
      end else begin
         pe = po && (mq.size() > 0);
         if (po && mq.size() == 0) m_udf = 1'b1;
         if (pe) void'(mq.pop_front());
         if (p) begin
            if (!is_legal(d)) begin
               if (m_drop < 255) m_drop++;
            end else if ((mq.size() + (pe ? 1 : 0)) < 8 || pe) begin
               mq.push_back(d);
            end else if (m_ovf < 255) begin
               m_ovf++;
            end
         end
      end
      bif.push_in = 1'b0;
      bif.pop     = 1'b0;
      reset       = 1'b1;
   endtask

   task automatic test_reset();
      drive(0, 32'h0, 0, 1);
      total++; if (bif.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bif.count); end
      total++; if (bif.pndng !== 1'b0) begin bad++; $display("FAIL reset_pndng got=%b exp=0", bif.pndng); end
      total++; if (bif.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bif.full); end
      total++; if (bif.D_pop !== 32'h0) begin bad++; $display("FAIL reset_dpop got=%h exp=0", bif.D_pop); end
      total++; if (bif.udf !== 1'b0) begin bad++; $display("FAIL reset_udf got=%b exp=0", bif.udf); end
   endtask

   task automatic test_fill_drain();
      logic [31:0] w;
      drive(0, 32'h0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         w = 32'h01000000 + 32'(i);
         drive(1, w, 0, 0);
         if (i == 0) begin
            total++; if (bif.pndng !== 1'b1) begin bad++; $display("FAIL first_pndng got=%b exp=1", bif.pndng); end
            total++; if (bif.D_pop !== 32'h01000000) begin bad++; $display("FAIL first_dpop got=%h exp=01000000", bif.D_pop); end
         end
      end
      total++; if (bif.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bif.full); end
      total++; if (bif.count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", bif.count); end
      drive(1, 32'h01000008, 0, 0);
      total++; if (bif.ovf_cnt !== 8'd1) begin bad++; $display("FAIL ovf_cnt got=%0d exp=1", bif.ovf_cnt); end
      total++; if (bif.count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", bif.count); end
      for (int i = 0; i < 8; i++) begin
         w = 32'h01000000 + 32'(i);
         total++; if (bif.D_pop !== w) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, bif.D_pop, w); end
         drive(0, 32'h0, 1, 0);
      end
      total++; if (bif.pndng !== 1'b0) begin bad++; $display("FAIL drain_pndng got=%b exp=0", bif.pndng); end
      total++; if (bif.count !== 4'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", bif.count); end
   endtask

   task automatic test_illegal_dest();
      drive(0, 32'h0, 0, 1);
      drive(1, 32'h05AAAAAA, 0, 0);
      drive(1, 32'h00BBBBBB, 0, 0);
      drive(1, 32'hFFCCCCCC, 0, 0);
      total++; if (bif.drop_cnt !== 8'd2) begin bad++; $display("FAIL drop_cnt got=%0d exp=2", bif.drop_cnt); end
      total++; if (bif.count !== 4'd1) begin bad++; $display("FAIL drop_count got=%0d exp=1", bif.count); end
      total++; if (bif.D_pop !== 32'hFFCCCCCC) begin bad++; $display("FAIL drop_dpop got=%h exp=ffcccccc", bif.D_pop); end
      total++; if (bif.ovf_cnt !== 8'd0) begin bad++; $display("FAIL drop_ovf got=%0d exp=0", bif.ovf_cnt); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] w;
      drive(0, 32'h0, 0, 1);
      for (int i = 0; i < 8; i++) drive(1, 32'h02000000 + 32'(i), 0, 0);
      total++; if (bif.D_pop !== 32'h02000000) begin bad++; $display("FAIL fpp_head got=%h exp=02000000", bif.D_pop); end
      drive(1, 32'h02000009, 1, 0);
      total++; if (bif.count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", bif.count); end
      total++; if (bif.ovf_cnt !== 8'd0) begin bad++; $display("FAIL fpp_ovf got=%0d exp=0", bif.ovf_cnt); end
      for (int i = 1; i <= 8; i++) begin
         w = (i == 8) ? 32'h02000009 : 32'h02000000 + 32'(i);
         total++; if (bif.D_pop !== w) begin bad++; $display("FAIL fpp_pop_%0d got=%h exp=%h", i, bif.D_pop, w); end
         drive(0, 32'h0, 1, 0);
      end
   endtask

   task automatic test_wrap();
      int nn;
      int k;
      logic [31:0] w;
      drive(0, 32'h0, 0, 1);
      drive(1, 32'h03000000, 0, 0);
      drive(1, 32'h03000001, 0, 0);
      nn = 2; k = 0;
      for (int c = 0; c < 20; c++) begin
         if (c % 2 == 0) begin
            drive(1, 32'h03000000 + 32'(nn), 0, 0);
            nn++;
         end else begin
            w = 32'h03000000 + 32'(k);
            total++; if (bif.D_pop !== w) begin bad++; $display("FAIL wrap_pop_%0d got=%h exp=%h", k, bif.D_pop, w); end
            drive(0, 32'h0, 1, 0);
            k++;
         end
         total++; if (bif.count > 4'd3) begin bad++; $display("FAIL wrap_count got=%0d exp<=3", bif.count); end
      end
      total++; if (bif.udf !== 1'b0) begin bad++; $display("FAIL wrap_udf got=%b exp=0", bif.udf); end
      total++; if (bif.count !== 4'(mq.size())) begin bad++; $display("FAIL wrap_final_count got=%0d exp=%0d", bif.count, mq.size()); end
   endtask

   task automatic test_underflow();
      drive(0, 32'h0, 0, 1);
      drive(0, 32'h0, 1, 0);
      total++; if (bif.udf !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", bif.udf); end
      total++; if (bif.count !== 4'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", bif.count); end
      total++; if (bif.D_pop !== 32'h0) begin bad++; $display("FAIL udf_dpop got=%h exp=0", bif.D_pop); end
      drive(0, 32'h0, 0, 0);
      total++; if (bif.udf !== 1'b1) begin bad++; $display("FAIL udf_sticky got=%b exp=1", bif.udf); end
      drive(1, 32'h01ABCDEF, 1, 0);
      total++; if (bif.count !== 4'd1) begin bad++; $display("FAIL udf_push_count got=%0d exp=1", bif.count); end
      total++; if (bif.D_pop !== 32'h01ABCDEF) begin bad++; $display("FAIL udf_push_dpop got=%h exp=01abcdef", bif.D_pop); end
   endtask

   task automatic test_reset_midstream();
      drive(0, 32'h0, 0, 1);
      drive(0, 32'h0, 1, 0);
      drive(1, 32'h01000001, 0, 0);
      drive(1, 32'h02000002, 0, 0);
      drive(1, 32'h03000003, 0, 0);
      drive(1, 32'h07000000, 0, 0);
      drive(1, 32'h01000055, 0, 1);
      total++; if (bif.count !== 4'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", bif.count); end
      total++; if (bif.pndng !== 1'b0) begin bad++; $display("FAIL mrst_pndng got=%b exp=0", bif.pndng); end
      total++; if (bif.full !== 1'b0) begin bad++; $display("FAIL mrst_full got=%b exp=0", bif.full); end
      total++; if (bif.ovf_cnt !== 8'd0) begin bad++; $display("FAIL mrst_ovf got=%0d exp=0", bif.ovf_cnt); end
      total++; if (bif.drop_cnt !== 8'd0) begin bad++; $display("FAIL mrst_drop got=%0d exp=0", bif.drop_cnt); end
      total++; if (bif.udf !== 1'b0) begin bad++; $display("FAIL mrst_udf got=%b exp=0", bif.udf); end
      total++; if (bif.D_pop !== 32'h0) begin bad++; $display("FAIL mrst_dpop got=%h exp=0", bif.D_pop); end
   endtask

   task automatic test_saturation();
      drive(0, 32'h0, 0, 1);
      for (int i = 0; i < 260; i++) drive(1, 32'h09000000 + 32'(i), 0, 0);
      total++; if (bif.drop_cnt !== 8'hFF) begin bad++; $display("FAIL drop_sat got=%0d exp=255", bif.drop_cnt); end
      for (int i = 0; i < 8; i++) drive(1, 32'h01000000 + 32'(i), 0, 0);
      for (int i = 0; i < 260; i++) drive(1, 32'h02000000 + 32'(i), 0, 0);
      total++; if (bif.ovf_cnt !== 8'hFF) begin bad++; $display("FAIL ovf_sat got=%0d exp=255", bif.ovf_cnt); end
   endtask

   task automatic test_random();
      logic [7:0]  dsts [8];
      logic [31:0] d;
      bit          p, po;
      dsts = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'hFF, 8'd2};
      drive(0, 32'h0, 0, 1);
      for (int c = 0; c < 400; c++) begin
         p  = ($urandom_range(0, 9) < 6);
         po = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 6));
         d  = {dsts[$urandom_range(0, 7)], 24'($urandom)};
         drive(p, d, po, 0);
         total++; if (bif.count !== 4'(mq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bif.count, mq.size()); end
         total++; if (bif.pndng !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_pndng c=%0d got=%b exp=%b", c, bif.pndng, mq.size() != 0); end
         total++; if (bif.full !== (mq.size() == 8)) begin bad++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, bif.full, mq.size() == 8); end
         if (mq.size() != 0) begin
            total++; if (bif.D_pop !== mq[0]) begin bad++; $display("FAIL rnd_dpop c=%0d got=%h exp=%h", c, bif.D_pop, mq[0]); end
         end
         total++; if (bif.ovf_cnt !== 8'(m_ovf)) begin bad++; $display("FAIL rnd_ovf c=%0d got=%0d exp=%0d", c, bif.ovf_cnt, m_ovf); end
         total++; if (bif.drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, bif.drop_cnt, m_drop); end
         total++; if (bif.udf !== m_udf) begin bad++; $display("FAIL rnd_udf c=%0d got=%b exp=%b", c, bif.udf, m_udf); end
      end
   endtask

   initial begin
      bif.push_in = 1'b0;
      bif.D_in    = '0;
      bif.pop     = 1'b0;
      @(negedge clk);
      test_reset();
      test_fill_drain();
      test_illegal_dest();
      test_full_push_pop();
      test_wrap();
      test_underflow();
      test_reset_midstream();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
